// File: rtl/noc_out_port_arbiter.sv
// Output-port arbiter for a wormhole NoC router: round-robin packet-level
// arbitration across input VCs with per-VC downstream credit tracking.
module noc_out_port_arbiter #(
  parameter int NUM_VC     = 4,
  parameter int DATA_W     = 128,
  parameter int CREDIT_MAX = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_VC-1:0]           in_valid,
  input  logic [NUM_VC*DATA_W-1:0]    in_flit,
  output logic [NUM_VC-1:0]           in_ready,
  output logic                        out_valid,
  output logic [DATA_W-1:0]           out_flit,
  output logic [$clog2(NUM_VC)-1:0]   out_vc,
  input  logic                        credit_valid,
  input  logic [$clog2(NUM_VC)-1:0]   credit_vc,
  output logic                        err_credit_ovf
);

  localparam int VW = $clog2(NUM_VC);
  localparam int CW = $clog2(CREDIT_MAX + 1);
  localparam logic [3:0]    HEAD_H    = 4'hA;
  localparam logic [3:0]    TAIL_H    = 4'hC;
  localparam logic [CW-1:0] CRED_FULL = CW'(CREDIT_MAX);

  typedef enum logic {IDLE, LOCKED} state_t;

  // A simultaneous transfer and return cancel; a return to a full counter saturates.
  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur,
                                                input logic dec, input logic inc);
    if (dec && !inc)
      credit_next = cur - CW'(1);
    else if (inc && !dec && (cur != CRED_FULL))
      credit_next = cur + CW'(1);
    else
      credit_next = cur;
  endfunction

  function automatic logic credit_ovf(input logic [CW-1:0] cur,
                                      input logic dec, input logic inc);
    credit_ovf = inc && !dec && (cur == CRED_FULL);
  endfunction

  state_t            state_q, state_d;
  logic [VW-1:0]     lock_vc_q, lock_vc_d;
  logic [VW-1:0]     rr_ptr_q, rr_ptr_d;
  logic [CW-1:0]     credit_q [NUM_VC];
  logic              err_q;

  logic [NUM_VC-1:0] is_head, is_tail, has_credit, credit_ret, ovf_vec;
  logic [NUM_VC-1:0] grant;
  logic              found;
  int                idx;

  logic              vld_p0;
  logic [VW-1:0]     vc_p0;
  logic [DATA_W-1:0] flit_p0;
  logic              vld_p1;
  logic [VW-1:0]     vc_p1;
  logic [DATA_W-1:0] flit_p1;

  always_comb begin
    is_head    = '0;
    is_tail    = '0;
    has_credit = '0;
    credit_ret = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      is_head[i]    = (in_flit[i*DATA_W + DATA_W-1 -: 4] == HEAD_H);
      is_tail[i]    = (in_flit[i*DATA_W + DATA_W-1 -: 4] == TAIL_H);
      has_credit[i] = (credit_q[i] != '0);
      credit_ret[i] = credit_valid && (credit_vc == VW'(i));
    end
  end

  // IDLE grants a head flit combinationally; LOCKED follows the locked VC until its tail.
  always_comb begin
    state_d   = state_q;
    lock_vc_d = lock_vc_q;
    rr_ptr_d  = rr_ptr_q;
    grant     = '0;
    found     = 1'b0;
    idx       = 0;
    case (state_q)
      IDLE: begin
        for (int k = 0; k < NUM_VC; k++) begin
          idx = int'(rr_ptr_q) + k;
          if (idx >= NUM_VC) idx = idx - NUM_VC;
          if (!found && in_valid[idx] && is_head[idx] && has_credit[idx]) begin
            found      = 1'b1;
            grant[idx] = 1'b1;
            lock_vc_d  = VW'(idx);
          end
        end
        if (found) state_d = LOCKED;
      end
      LOCKED: begin
        if (in_valid[lock_vc_q] && has_credit[lock_vc_q]) begin
          grant[lock_vc_q] = 1'b1;
          if (is_tail[lock_vc_q]) begin
            state_d  = IDLE;
            rr_ptr_d = (lock_vc_q == VW'(NUM_VC-1)) ? '0 : lock_vc_q + VW'(1);
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign in_ready = rst_n ? grant : '0;

  always_comb begin
    ovf_vec = '0;
    for (int i = 0; i < NUM_VC; i++)
      ovf_vec[i] = credit_ovf(credit_q[i], in_ready[i], credit_ret[i]);
  end

  // Stage p0: selected flit of the granted VC
  always_comb begin
    vc_p0 = '0;
    for (int i = 0; i < NUM_VC; i++)
      if (grant[i]) vc_p0 = VW'(i);
  end

  assign vld_p0  = |in_ready;
  assign flit_p0 = in_flit[int'(vc_p0)*DATA_W +: DATA_W];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      lock_vc_q <= '0;
      rr_ptr_q  <= '0;
      vld_p1    <= 1'b0;
      err_q     <= 1'b0;
      for (int i = 0; i < NUM_VC; i++) credit_q[i] <= CRED_FULL;
    end else begin
      state_q   <= state_d;
      lock_vc_q <= lock_vc_d;
      rr_ptr_q  <= rr_ptr_d;
      vld_p1    <= vld_p0;
      if (|ovf_vec) err_q <= 1'b1;
      for (int i = 0; i < NUM_VC; i++)
        credit_q[i] <= credit_next(credit_q[i], in_ready[i], credit_ret[i]);
    end
  end

  // Stage p1: registered output flit, held when no transfer occurs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      flit_p1 <= '0;
      vc_p1   <= '0;
    end else if (vld_p0) begin
      flit_p1 <= flit_p0;
      vc_p1   <= vc_p0;
    end
  end

  assign out_valid      = vld_p1;
  assign out_flit       = flit_p1;
  assign out_vc         = vc_p1;
  assign err_credit_ovf = err_q;

endmodule

// File: tb/tb_noc_out_port_arbiter.sv
// Directed bench for noc_out_port_arbiter; expected output flits go into a
// scoreboard queue at issue time and a negedge monitor compares them.
module tb_noc_out_port_arbiter;

  localparam int NUM_VC = 4;
  localparam int DATA_W = 128;

  logic                     clk;
  logic                     rst_n;
  logic [NUM_VC-1:0]        in_valid;
  logic [NUM_VC*DATA_W-1:0] in_flit;
  logic [NUM_VC-1:0]        in_ready;
  logic                     out_valid;
  logic [DATA_W-1:0]        out_flit;
  logic [1:0]               out_vc;
  logic                     credit_valid;
  logic [1:0]               credit_vc;
  logic                     err_credit_ovf;

  int n_total = 0;
  int n_pass  = 0;
  logic [DATA_W+1:0] sbq [$];

  noc_out_port_arbiter #(.NUM_VC(NUM_VC), .DATA_W(DATA_W), .CREDIT_MAX(4)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_flit(in_flit),
    .in_ready(in_ready), .out_valid(out_valid), .out_flit(out_flit),
    .out_vc(out_vc), .credit_valid(credit_valid), .credit_vc(credit_vc),
    .err_credit_ovf(err_credit_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  function automatic logic [DATA_W-1:0] mk(input logic [3:0] t, input int id);
    logic [31:0] u;
    u  = id;
    mk = {t, 28'(u * 7), 32'hC0DE_0000 | u, u, ~u};
  endfunction

  task automatic drv(input int v, input logic [3:0] t, input int id);
    in_flit[v*DATA_W +: DATA_W] = mk(t, id);
    in_valid[v] = 1'b1;
  endtask

  // Check in_ready for this cycle, queue the expected output, advance one clock.
  task automatic step(input string nm, input logic [3:0] exp);
    #1;
    chk(nm, 128'(in_ready), 128'(exp));
    for (int i = 0; i < NUM_VC; i++)
      if (exp[i]) sbq.push_back({2'(i), in_flit[i*DATA_W +: DATA_W]});
    @(posedge clk); #1;
  endtask

  task automatic do_reset();
    in_valid = '0;
    credit_valid = 1'b0;
    @(negedge clk); #1;
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
  endtask

  always @(negedge clk) begin
    if (out_valid === 1'b1) begin
      if (sbq.size() == 0) begin
        n_total++;
        $display("FAIL sb_unexpected: got flit %0h vc %0d expected none", out_flit, out_vc);
      end else begin
        logic [DATA_W+1:0] e;
        e = sbq.pop_front();
        chk("sb_vc", 128'(out_vc), 128'(e[DATA_W +: 2]));
        chk("sb_flit", out_flit, e[DATA_W-1:0]);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst_n = 1'b0;
    in_valid = '0;
    in_flit = '0;
    credit_valid = 1'b0;
    credit_vc = '0;
    for (int v = 0; v < NUM_VC; v++) drv(v, 4'hA, v);
    #2;
    chk("rst_in_ready", 128'(in_ready), 128'(0));
    chk("rst_out_valid", 128'(out_valid), 128'(0));
    chk("rst_out_flit", out_flit, 128'(0));
    chk("rst_out_vc", 128'(out_vc), 128'(0));
    chk("rst_err", 128'(err_credit_ovf), 128'(0));
    in_valid = '0;
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // VC0 four-flit packet with full credits, then credit[0] exhausted
    drv(0, 4'hA, 1); step("t1_head", 4'b0001); chk("t1_ov0", 128'(out_valid), 128'(1));
    drv(0, 4'h0, 2); step("t1_body0", 4'b0001); chk("t1_ov1", 128'(out_valid), 128'(1));
    drv(0, 4'h0, 3); step("t1_body1", 4'b0001); chk("t1_ov2", 128'(out_valid), 128'(1));
    drv(0, 4'hC, 4); step("t1_tail", 4'b0001); chk("t1_ov3", 128'(out_valid), 128'(1));
    in_valid = '0;
    step("t1_idle", 4'b0000); chk("t1_ov_end", 128'(out_valid), 128'(0));
    drv(0, 4'hA, 5); step("t1_nocred", 4'b0000);

    // VC1 and VC2 heads together from rr_ptr=0
    do_reset();
    drv(1, 4'hA, 10); drv(2, 4'hA, 20); step("t2_g1", 4'b0010);
    drv(1, 4'h0, 11); step("t2_b1", 4'b0010);
    drv(1, 4'hC, 12); step("t2_t1", 4'b0010);
    in_valid[1] = 1'b0; step("t2_g2", 4'b0100);
    drv(2, 4'h0, 21); step("t2_b2", 4'b0100);
    drv(2, 4'hC, 22); step("t2_t2", 4'b0100);
    in_valid = '0;
    drv(2, 4'hA, 23); drv(3, 4'hA, 30); step("t2_rr3", 4'b1000);
    drv(3, 4'hC, 31); step("t2_t3", 4'b1000);
    in_valid = '0; step("t2_idle", 4'b0000);

    // VC0 stalls on credit mid-packet while VC3 waits
    do_reset();
    drv(3, 4'hA, 40); drv(0, 4'hA, 50); step("t3_head", 4'b0001);
    drv(0, 4'h0, 51); step("t3_b51", 4'b0001);
    drv(0, 4'h0, 52); step("t3_b52", 4'b0001);
    drv(0, 4'h0, 53); step("t3_b53", 4'b0001);
    drv(0, 4'h0, 54); step("t3_stall_a", 4'b0000); step("t3_stall_b", 4'b0000);
    credit_valid = 1'b1; credit_vc = 2'd0; step("t3_credcyc", 4'b0000);
    credit_valid = 1'b0; step("t3_resume", 4'b0001);
    drv(0, 4'hC, 55); step("t3_stall_c", 4'b0000);
    credit_valid = 1'b1; credit_vc = 2'd0; step("t3_credcyc2", 4'b0000);
    credit_valid = 1'b0; step("t3_tail", 4'b0001);
    in_valid[0] = 1'b0; step("t3_vc3", 4'b1000);
    drv(3, 4'hC, 41); step("t3_vc3_tail", 4'b1000);
    in_valid = '0;

    // Transfer and credit return on VC2 in the same cycle
    drv(2, 4'hA, 60); credit_valid = 1'b1; credit_vc = 2'd2; step("t4_head", 4'b0100);
    credit_valid = 1'b0;
    drv(2, 4'h0, 61); step("t4_b61", 4'b0100);
    drv(2, 4'h0, 62); step("t4_b62", 4'b0100);
    drv(2, 4'h0, 63); step("t4_b63", 4'b0100);
    drv(2, 4'hC, 64); step("t4_tail", 4'b0100);
    drv(2, 4'hA, 65); step("t4_nocred", 4'b0000);
    chk("t4_noovf", 128'(err_credit_ovf), 128'(0));
    in_valid = '0;

    // Credit return to a full counter
    credit_valid = 1'b1; credit_vc = 2'd1; step("t5_ret", 4'b0000);
    credit_valid = 1'b0;
    chk("t5_err_set", 128'(err_credit_ovf), 128'(1));
    drv(1, 4'hA, 70); step("t5_head", 4'b0010);
    drv(1, 4'h0, 71); step("t5_b71", 4'b0010);
    drv(1, 4'h0, 72); step("t5_b72", 4'b0010);
    drv(1, 4'hC, 73); step("t5_tail", 4'b0010);
    drv(1, 4'hA, 74); step("t5_cap", 4'b0000);
    in_valid = '0;
    step("t5_idle", 4'b0000);
    chk("t5_err_sticky", 128'(err_credit_ovf), 128'(1));

    // Reset pulse during a VC2 packet
    do_reset();
    chk("t6_err_clr", 128'(err_credit_ovf), 128'(0));
    drv(2, 4'hA, 80); step("t6_head", 4'b0100);
    drv(2, 4'h0, 81); step("t6_b81", 4'b0100);
    drv(2, 4'h0, 82);
    @(negedge clk); #1;
    rst_n = 1'b0;
    #1;
    chk("t6_async_ov", 128'(out_valid), 128'(0));
    chk("t6_async_flit", out_flit, 128'(0));
    chk("t6_async_vc", 128'(out_vc), 128'(0));
    chk("t6_async_rdy", 128'(in_ready), 128'(0));
    @(posedge clk); #1;
    chk("t6_hold_rdy", 128'(in_ready), 128'(0));
    @(negedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    step("t6_body", 4'b0000);
    drv(2, 4'hC, 83); step("t6_tail", 4'b0000);
    drv(2, 4'hA, 84); drv(0, 4'hA, 90); step("t6_vc0", 4'b0001);
    drv(0, 4'hC, 91); step("t6_vc0_tail", 4'b0001);
    in_valid = '0;
    step("t6_done", 4'b0000);
    chk("sb_empty", 128'(sbq.size()), 128'(0));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
